nand_phy_ctl_seq: RTL and testbench
===================================

NAND_PHY_CTL_SEQ -- requirements
Module: nand_phy_ctl_seq

Interface
REQ-001 SHALL have parameter CENS_PER_IO, default 2, number of chip-enable outputs (1..8).
REQ-002 SHALL have parameter RBS_PER_IO, default 2, number of ready/busy inputs (1..8).
REQ-003 SHALL have parameter TW, default 4, width of timing config fields.
REQ-004 SHALL have parameter RB_FILTER, default 4, consecutive stable samples required to update a ready/busy output (>=1).
REQ-005 SHALL have parameter CE_W, default 1, width of req_ce (CENS_PER_IO <= 2**CE_W).
REQ-006 SHALL have ports:
  clk0  in  1  sole clock, all logic on rising edge
  rst0  in  1  reset, synchronous, active-high
  req_valid  in  1  latch-cycle request valid
  req_ready  out  1  request accepted when req_valid & req_ready
  req_type  in  1  0 = command cycle (CLE), 1 = address cycle (ALE)
  req_data  in  8  byte to drive on DQ
  req_ce  in  CE_W  target chip-enable index
  req_last  in  1  1 = release CE after this cycle
  cfg_twp  in  TW  WE# low time in clk0 cycles
  cfg_twh  in  TW  WE# high hold time in clk0 cycles
  ctrl_wpn  in  1  write-protect request from controller
  cle  out  1  command latch enable
  ale  out  1  address latch enable
  wrn  out  1  write enable, active low
  wpn  out  1  write protect, active low
  cen  out  CENS_PER_IO  chip enables, active low
  dq_out  out  8  DQ output byte
  dq_oe  out  1  DQ output enable
  rb  in  RBS_PER_IO  raw ready/busy pins, asynchronous
  ctrl_rb  out  RBS_PER_IO  synchronised, filtered ready/busy (1 = ready)
  busy  out  1  sequencer not idle

Function
REQ-007 SHALL drive every pin output (cle, ale, wrn, wpn, cen, dq_out, dq_oe) directly from a flop, no logic after the flop.
REQ-008 SHALL implement FSM states IDLE, SETUP, WE_LOW, WE_HIGH.
REQ-009 SHALL assert req_ready only in IDLE; busy = (state != IDLE).
REQ-010 On acceptance in IDLE, SHALL capture req_type, req_data, req_ce, req_last, cfg_twp, cfg_twh and go to SETUP; later changes to inputs SHALL have no effect on the cycle in progress.
REQ-011 SETUP (1 cycle): cen[req_ce]=0, other cen bits=1; cle=~req_type, ale=req_type; dq_out=req_data; dq_oe=1; wrn=1; then WE_LOW.
REQ-012 WE_LOW: wrn=0 for max(cfg_twp,1) cycles, other pins unchanged from SETUP; then WE_HIGH.
REQ-013 WE_HIGH: wrn=1, cle/ale/dq_out/dq_oe held for max(cfg_twh,1) cycles; then IDLE.
REQ-014 On entering IDLE: cle=0, ale=0, dq_oe=0; cen all 1 if captured req_last=1, else selected cen stays 0 until next acceptance.
REQ-015 A request whose req_ce >= CENS_PER_IO SHALL be accepted and sequenced with all cen bits held 1.
REQ-016 Total request duration, acceptance to next req_ready, SHALL be 1 + max(twp,1) + max(twh,1) + 1 cycles.
REQ-017 wpn SHALL equal ctrl_wpn delayed by one cycle, independent of FSM state.
REQ-018 Each rb bit SHALL pass a 2-flop synchroniser; ctrl_rb[i] SHALL change only after the synchronised value differs from ctrl_rb[i] for RB_FILTER consecutive cycles; any intervening match restarts the count.
REQ-019 Pin-to-ctrl_rb latency for a clean edge SHALL be 2 + RB_FILTER cycles.

Reset
REQ-020 While rst0=1 at a clock edge: state=IDLE, cen all 1, wrn=1, cle=0, ale=0, wpn=0, dq_out=0, dq_oe=0, ctrl_rb all 0, synchroniser and filter counters cleared, busy=0.
REQ-021 rst0 asserted mid-request SHALL abort it; reset values appear on the cycle after the edge; no further WE# pulse.
REQ-022 First request SHALL be accepted in the first cycle after rst0 deasserts.

Verification
REQ-023 Command 0x70, ce=1, last=1, twp=2, twh=1 -> cen=2'b01, cle=1, dq_out=0x70 for 4 cycles; wrn low exactly 2 cycles; req_ready again 5 cycles after acceptance; cen=2'b11 after.
REQ-024 Address 0xA5 with last=0, then command 0x30 with last=1, both ce=0, twp=twh=0 -> cen[0] held low across both requests, two 1-cycle WE# pulses, ale then cle, cen released after second.
REQ-025 rb[0] glitch low 3 cycles with RB_FILTER=4 -> ctrl_rb[0] unchanged; rb[0] low 10 cycles -> ctrl_rb[0] falls 6 cycles after pin edge.
REQ-026 rst0 pulsed during WE_LOW -> wrn=1, cen all 1, dq_oe=0 next cycle, busy=0.
REQ-027 req_ce=3 with CENS_PER_IO=2 -> full WE# sequence, cen stays 2'b11.
REQ-028 ctrl_wpn toggled during a request -> wpn follows with 1-cycle latency, request timing unaffected.

Source files
------------

// File: rtl/nand_phy_ctl_seq.sv
// NAND PHY latch-cycle sequencer: drives one CLE/ALE byte per request with programmable WE# timing.
// Latency: 1 SETUP + max(twp,1) WE_LOW + max(twh,1) WE_HIGH cycles, then back to IDLE.
// Backpressure: req_ready only in IDLE; ready/busy pins are synchronised and glitch-filtered.
module nand_phy_ctl_seq #(
  parameter int CENS_PER_IO = 2,
  parameter int RBS_PER_IO  = 2,
  parameter int TW          = 4,
  parameter int RB_FILTER   = 4,
  parameter int CE_W        = 1
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_type,
  input  logic [7:0]             req_data,
  input  logic [CE_W-1:0]        req_ce,
  input  logic                   req_last,
  input  logic [TW-1:0]          cfg_twp,
  input  logic [TW-1:0]          cfg_twh,
  input  logic                   ctrl_wpn,
  output logic                   cle,
  output logic                   ale,
  output logic                   wrn,
  output logic                   wpn,
  output logic [CENS_PER_IO-1:0] cen,
  output logic [7:0]             dq_out,
  output logic                   dq_oe,
  input  logic [RBS_PER_IO-1:0]  rb,
  output logic [RBS_PER_IO-1:0]  ctrl_rb,
  output logic                   busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] WE_LOW  = 2'd2;
  localparam logic [1:0] WE_HIGH = 2'd3;

  localparam int FCW = (RB_FILTER > 1) ? $clog2(RB_FILTER) : 1;
  localparam logic [FCW-1:0] FMAX = FCW'(RB_FILTER - 1);

  logic [1:0]             state;
  logic [TW-1:0]          cnt;
  logic [TW-1:0]          twp_q;
  logic [TW-1:0]          twh_q;
  logic                   last_q;
  logic [CENS_PER_IO-1:0] cen_sel;

  logic [RBS_PER_IO-1:0]  rb_s1;
  logic [RBS_PER_IO-1:0]  rb_s2;
  logic [FCW-1:0]         fcnt [RBS_PER_IO];

  // Phase length counts down to zero; a zero config still yields one cycle.
  function automatic logic [TW-1:0] phase_cnt(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Active-low one-hot chip enable; an out-of-range index selects nothing.
  always_comb begin
    cen_sel = '1;
    for (int i = 0; i < CENS_PER_IO; i++) begin
      cen_sel[i] = (32'(req_ce) != 32'(i));
    end
  end

  // Latch-cycle FSM; all pins are registered here so no logic follows the flops.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state  <= IDLE;
      cnt    <= '0;
      twp_q  <= '0;
      twh_q  <= '0;
      last_q <= 1'b0;
      cen    <= '1;
      wrn    <= 1'b1;
      cle    <= 1'b0;
      ale    <= 1'b0;
      dq_out <= '0;
      dq_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state  <= SETUP;
            cen    <= cen_sel;
            cle    <= ~req_type;
            ale    <= req_type;
            dq_out <= req_data;
            dq_oe  <= 1'b1;
            wrn    <= 1'b1;
            last_q <= req_last;
            twp_q  <= cfg_twp;
            twh_q  <= cfg_twh;
          end
        end
        SETUP: begin
          state <= WE_LOW;
          wrn   <= 1'b0;
          cnt   <= phase_cnt(twp_q);
        end
        WE_LOW: begin
          if (cnt == '0) begin
            state <= WE_HIGH;
            wrn   <= 1'b1;
            cnt   <= phase_cnt(twh_q);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WE_HIGH: begin
          if (cnt == '0) begin
            state <= IDLE;
            cle   <= 1'b0;
            ale   <= 1'b0;
            dq_oe <= 1'b0;
            if (last_q) cen <= '1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write protect is a straight one-cycle retime of the controller request.
  always_ff @(posedge clk0) begin
    if (rst0) wpn <= 1'b0;
    else      wpn <= ctrl_wpn;
  end

  // Ready/busy: 2-flop synchroniser, then output flips only after RB_FILTER consecutive differing samples.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rb_s1   <= '0;
      rb_s2   <= '0;
      ctrl_rb <= '0;
      for (int i = 0; i < RBS_PER_IO; i++) fcnt[i] <= '0;
    end else begin
      rb_s1 <= rb;
      rb_s2 <= rb_s1;
      for (int i = 0; i < RBS_PER_IO; i++) begin
        if (rb_s2[i] != ctrl_rb[i]) begin
          if (fcnt[i] == FMAX) begin
            ctrl_rb[i] <= rb_s2[i];
            fcnt[i]    <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nand_phy_ctl_seq.sv
// Self-checking bench for nand_phy_ctl_seq: directed and randomised latch cycles, reset abort, RB filter.
// Expected pin traces are built from the per-phase timing rules; RB expectations from a sample-window model.
// Inputs are driven and outputs sampled on the falling edge of clk0.
module tb_nand_phy_ctl_seq;

  localparam int CN = 2;
  localparam int RN = 2;
  localparam int TWD = 4;
  localparam int RF = 4;
  localparam int CW = 2;

  logic           clk0 = 1'b0;
  logic           rst0 = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_type = 1'b0;
  logic [7:0]     req_data = 8'h00;
  logic [CW-1:0]  req_ce = '0;
  logic           req_last = 1'b0;
  logic [TWD-1:0] cfg_twp = '0;
  logic [TWD-1:0] cfg_twh = '0;
  logic           ctrl_wpn = 1'b0;
  logic           cle, ale, wrn, wpn, dq_oe, busy;
  logic [CN-1:0]  cen;
  logic [7:0]     dq_out;
  logic [RN-1:0]  rb = '1;
  logic [RN-1:0]  ctrl_rb;

  int passed = 0;
  int total  = 0;
  logic wpn_drv = 1'b0;
  logic rst_s;
  logic [CN-1:0] cen_hold = '1;
  logic [RN-1:0] rb_exp = '1;
  logic [RN-1:0] hist[$];

  always #5 clk0 = ~clk0;

  always @(posedge clk0) rst_s <= rst0;

  nand_phy_ctl_seq #(
    .CENS_PER_IO(CN), .RBS_PER_IO(RN), .TW(TWD), .RB_FILTER(RF), .CE_W(CW)
  ) dut (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_data(req_data), .req_ce(req_ce), .req_last(req_last),
    .cfg_twp(cfg_twp), .cfg_twh(cfg_twh), .ctrl_wpn(ctrl_wpn),
    .cle(cle), .ale(ale), .wrn(wrn), .wpn(wpn), .cen(cen), .dq_out(dq_out),
    .dq_oe(dq_oe), .rb(rb), .ctrl_rb(ctrl_rb), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One cycle: wait for the falling edge, check wpn retiming, drive a fresh random ctrl_wpn.
  task automatic tick();
    @(negedge clk0);
    chk("wpn", 32'(wpn), rst_s ? 32'd0 : 32'(wpn_drv));
    wpn_drv  = 1'($urandom_range(0, 1));
    ctrl_wpn = wpn_drv;
  endtask

  task automatic chk_pins(input string tg, input logic ecle, input logic eale, input logic ewrn,
                          input logic eoe, input logic [7:0] edq, input logic [CN-1:0] ecen,
                          input logic ebusy, input bit do_dq);
    chk({tg, ".cle"},   32'(cle),   32'(ecle));
    chk({tg, ".ale"},   32'(ale),   32'(eale));
    chk({tg, ".wrn"},   32'(wrn),   32'(ewrn));
    chk({tg, ".dq_oe"}, 32'(dq_oe), 32'(eoe));
    chk({tg, ".cen"},   32'(cen),   32'(ecen));
    chk({tg, ".busy"},  32'(busy),  32'(ebusy));
    chk({tg, ".ready"}, 32'(req_ready), 32'(!ebusy));
    if (do_dq) chk({tg, ".dq_out"}, 32'(dq_out), 32'(edq));
  endtask

  task automatic scramble();
    req_valid = 1'($urandom_range(0, 1));
    req_type  = 1'($urandom_range(0, 1));
    req_data  = 8'($urandom);
    req_ce    = CW'($urandom);
    req_last  = 1'($urandom_range(0, 1));
    cfg_twp   = TWD'($urandom);
    cfg_twh   = TWD'($urandom);
  endtask

  // Issue one request at the current falling edge and check every cycle up to the return to IDLE.
  task automatic do_req(input logic typ, input logic [7:0] data, input logic [CW-1:0] ce,
                        input logic last, input int twp, input int twh);
    logic [CN-1:0] act;
    int nwp, nwh;
    act = (int'(ce) < CN) ? ~(CN'(1) << ce) : '1;
    nwp = (twp == 0) ? 1 : twp;
    nwh = (twh == 0) ? 1 : twh;
    chk("accept.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_type  = typ;
    req_data  = data;
    req_ce    = ce;
    req_last  = last;
    cfg_twp   = TWD'(twp);
    cfg_twh   = TWD'(twh);
    for (int k = 0; k <= nwp + nwh; k++) begin
      tick();
      chk_pins("seq", ~typ, typ, !(k >= 1 && k <= nwp), 1'b1, data, act, 1'b1, 1'b1);
      scramble();
    end
    tick();
    req_valid = 1'b0;
    cen_hold  = last ? '1 : act;
    chk_pins("idle", 1'b0, 1'b0, 1'b1, 1'b0, data, cen_hold, 1'b0, 1'b0);
  endtask

  // RB model: output flips once the last RF synchronised samples all disagree with it.
  // Sample seen by the filter at the edge before falling edge k is the pin value driven at k-3.
  task automatic rb_step(input logic [RN-1:0] v);
    tick();
    for (int b = 0; b < RN; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 0; j < RF; j++)
        if (hist[hist.size() - 3 - j][b] == rb_exp[b]) all_diff = 1'b0;
      if (all_diff) rb_exp[b] = ~rb_exp[b];
    end
    chk("ctrl_rb", 32'(ctrl_rb), 32'(rb_exp));
    rb = v;
    hist.push_back(v);
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    chk_pins("reset", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, '1, 1'b0, 1'b1);
    chk("reset.ctrl_rb", 32'(ctrl_rb), 32'd0);

    // First request accepted on the first cycle after reset release; command 0x70 on ce 1
    rst0 = 1'b0;
    do_req(1'b0, 8'h70, 2'd1, 1'b1, 2, 1);

    // Address then command on ce 0 with CE held across both
    do_req(1'b1, 8'hA5, 2'd0, 1'b0, 0, 0);
    do_req(1'b0, 8'h30, 2'd0, 1'b1, 0, 0);

    // Out-of-range chip enable: full sequence, no CE asserted
    do_req(1'b1, 8'h3C, 2'd3, 1'b1, 3, 2);

    // Randomised requests with idle gaps; CE hold checked during gaps
    for (int r = 0; r < 10; r++) begin
      do_req(1'($urandom_range(0, 1)), 8'($urandom), CW'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        chk("gap.cen", 32'(cen), 32'(cen_hold));
        chk("gap.ready", 32'(req_ready), 32'd1);
      end
    end

    // Reset asserted during WE_LOW aborts the cycle
    chk("abort.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_type = 1'b0; req_data = 8'h55; req_ce = 2'd0;
    req_last = 1'b0; cfg_twp = 4'd6; cfg_twh = 4'd2;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort.we_low", 32'(wrn), 32'd0);
    rst0 = 1'b1;
    tick();
    chk_pins("abort", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, '1, 1'b0, 1'b1);
    repeat (2) begin
      tick();
      chk("abort.hold_wrn", 32'(wrn), 32'd1);
    end
    rst0 = 1'b0;
    do_req(1'b0, 8'hFF, 2'd0, 1'b1, 1, 1);

    // Ready/busy filter: settle high, then glitch, long low, and random activity on bit 1
    rb = '1;
    repeat (10) tick();
    chk("rb.settle", 32'(ctrl_rb), 32'd3);
    rb_exp = '1;
    hist.delete();
    repeat (8) hist.push_back('1);
    for (int k = 0; k < 5; k++)  rb_step({1'($urandom_range(0, 1)), 1'b1});
    for (int k = 0; k < 3; k++)  rb_step({1'($urandom_range(0, 1)), 1'b0});
    for (int k = 0; k < 10; k++) begin
      rb_step({1'($urandom_range(0, 1)), 1'b1});
      chk("rb.glitch", 32'(ctrl_rb[0]), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      rb_step({1'($urandom_range(0, 1)), 1'b0});
      if (k >= 1) chk("rb.latency", 32'(ctrl_rb[0]), (k >= 6) ? 32'd0 : 32'd1);
    end
    for (int k = 0; k < 12; k++) rb_step({1'($urandom_range(0, 1)), 1'b1});
    begin
      logic [RN-1:0] v;
      int run;
      v = '1;
      run = 0;
      for (int k = 0; k < 80; k++) begin
        if (run == 0) begin
          v   = RN'($urandom);
          run = $urandom_range(1, 7);
        end
        run = run - 1;
        rb_step(v);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
